// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, column sync, debounced press/release, hex key code + valid strobe.
// Optional auto-repeat of Key_Valid while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int DIV_MAX      = 5000,
    parameter int DEB_TICKS    = 4,
    parameter int REPEAT_TICKS = 50
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST_N,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Down
);

    localparam int DW = $clog2(DIV_MAX + 1);

    if (DIV_MAX < 2) begin : g_chk_div
        $error("keypad_scanner: DIV_MAX must be >= 2");
    end
    if (DEB_TICKS < 1 || DEB_TICKS > 15) begin : g_chk_deb
        $error("keypad_scanner: DEB_TICKS must be in 1..15");
    end
    if (REPEAT_TICKS < 1) begin : g_chk_rep
        $error("keypad_scanner: REPEAT_TICKS must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t        r_state, w_state_nx;
    logic [DW-1:0] r_div_cnt;
    logic [3:0]    r_col_meta, r_col_sync;
    logic [1:0]    r_row_idx, w_row_nx;
    logic [1:0]    r_col_idx, w_col_nx;
    logic [3:0]    r_deb_cnt, w_deb_nx;
    logic [3:0]    r_key_code;
    logic          r_key_valid, r_key_down;
    logic          w_tick, w_any_low, w_lat_low;
    logic [1:0]    w_low_idx;
    logic          w_accept, w_down_clr, w_rep_clr, w_rep_fire;

    assign w_tick    = (r_div_cnt == DW'(DIV_MAX));
    assign w_any_low = (r_col_sync != 4'hF);
    assign w_lat_low = ~r_col_sync[r_col_idx];

    // Lowest-index low column wins when several keys share the scanned row.
    always_comb begin
        w_low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_col_sync[i]) w_low_idx = 2'(i);
        end
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
            r_div_cnt  <= '0;
        end else begin
            r_col_meta <= COL;
            r_col_sync <= r_col_meta;
            r_div_cnt  <= w_tick ? '0 : r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            r_state   <= S_IDLE;
            r_row_idx <= 2'd0;
            r_col_idx <= 2'd0;
            r_deb_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nx;
            r_row_idx <= w_row_nx;
            r_col_idx <= w_col_nx;
            r_deb_cnt <= w_deb_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row_idx;
        w_col_nx   = r_col_idx;
        w_deb_nx   = r_deb_cnt;
        w_accept   = 1'b0;
        w_down_clr = 1'b0;
        w_rep_clr  = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_low) begin
                        w_state_nx = S_SCAN;
                        w_row_nx   = 2'd0;
                    end
                end
                S_SCAN: begin
                    if (w_any_low) begin
                        w_col_nx   = w_low_idx;
                        w_deb_nx   = 4'd0;
                        w_state_nx = S_DEBOUNCE;
                    end else if (r_row_idx == 2'd3) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_row_nx = r_row_idx + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_lat_low) begin
                        w_state_nx = S_IDLE;
                    end else if (r_deb_cnt + 4'd1 == 4'(DEB_TICKS)) begin
                        w_state_nx = S_PRESSED;
                        w_accept   = 1'b1;
                    end else begin
                        w_deb_nx = r_deb_cnt + 4'd1;
                    end
                end
                S_PRESSED: begin
                    if (!w_lat_low) begin
                        w_state_nx = S_RELEASE;
                        w_deb_nx   = 4'd0;
                    end
                end
                S_RELEASE: begin
                    if (w_lat_low) begin
                        w_state_nx = S_PRESSED;
                        w_rep_clr  = 1'b1;
                    end else if (r_deb_cnt + 4'd1 == 4'(DEB_TICKS)) begin
                        w_state_nx = S_IDLE;
                        w_down_clr = 1'b1;
                    end else begin
                        w_deb_nx = r_deb_cnt + 4'd1;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // Idle drives all rows low so any key wakes the scanner; otherwise one row is strobed.
    always_comb begin
        ROW = 4'hF;
        if (r_state == S_IDLE) ROW = 4'h0;
        else                   ROW[r_row_idx] = 1'b0;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0] r_rep_cnt;

    assign w_rep_fire = w_tick && (r_state == S_PRESSED) && w_lat_low &&
                        (r_rep_cnt == RW'(REPEAT_TICKS - 1));

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N)                           r_rep_cnt <= '0;
        else if (w_accept || w_rep_clr || w_rep_fire) r_rep_cnt <= '0;
        else if (w_tick && r_state == S_PRESSED)  r_rep_cnt <= r_rep_cnt + 1'b1;
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge Sys_CLK or negedge Sys_RST_N) begin
        if (!Sys_RST_N) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_key_valid <= w_accept | w_rep_fire;
            if (w_accept)        r_key_code <= {r_row_idx, r_col_idx};
            if (w_accept)        r_key_down <= 1'b1;
            else if (w_down_clr) r_key_down <= 1'b0;
        end
    end

    assign Key_Code  = r_key_code;
    assign Key_Valid = r_key_valid;
    assign Key_Down  = r_key_down;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives COL, expected key events are queued
// with their expected arrival edge, and a monitor pops and compares on every Key_Valid.
module tb_keypad_scanner;
    localparam int DIV_MAX = 3;
    localparam int DEB     = 4;
    localparam int REP     = 10;
    localparam int TPER    = DIV_MAX + 1;

    typedef struct {
        logic [3:0] code;
        int         edge_at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col, row, code;
    logic        valid, down;
    logic [15:0] keys = 16'h0;
    int          edge_n;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    exp_t        mon_e;

    always #5 clk = ~clk;

    keypad_scanner #(.DIV_MAX(DIV_MAX), .DEB_TICKS(DEB), .REPEAT_TICKS(REP)) dut (
        .Sys_CLK   (clk),
        .Sys_RST_N (rst_n),
        .COL       (col),
        .ROW       (row),
        .Key_Code  (code),
        .Key_Valid (valid),
        .Key_Down  (down)
    );

    // Passive 4x4 matrix: a pressed key pulls its column low when its row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
    end

    // Bench-side copy of the tick grid: tick-driven state updates land on edges that are multiples of TPER.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    always @(negedge clk) begin
        if (rst_n && valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got code %0h at edge %0d, expected no pulse", code, edge_n);
            end else begin
                mon_e = q.pop_front();
                if (code !== mon_e.code || edge_n != mon_e.edge_at) begin
                    errors++;
                    $display("FAIL key_valid: got code %0h at edge %0d, expected code %0h at edge %0d",
                             code, edge_n, mon_e.code, mon_e.edge_at);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (TPER * n) @(negedge clk);
    endtask

    task automatic align();
        while (edge_n % TPER != 0) @(negedge clk);
    endtask

    // Press key k (row r) right after a tick edge and queue its expected acceptance.
    task automatic press(input int k, input int r);
        keys[k] = 1'b1;
        q.push_back('{4'(k), edge_n + TPER * (2 + r + DEB)});
    endtask

    int a_edge;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_row", row, 4'h0);
        check("rst_code", code, 4'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_down", down, 1'b0);
        rst_n = 1'b1;
        wait_ticks(2);

        // Clean press of key 9 (row 2, col 1) held 40 ticks.
        align();
        press(9, 2);
        wait_ticks(40);
        check("t1_down_held", down, 1'b1);
        check("t1_row_latched", row, 4'b1011);
        keys = 16'h0;
        wait_ticks(3);
        check("t1_down_during_release", down, 1'b1);
        wait_ticks(3);
        check("t1_down_released", down, 1'b0);
        check("t1_row_idle", row, 4'h0);
        wait_ticks(4);

        // Bounce: key 2 (row 0) low for 2 ticks only.
        align();
        keys[2] = 1'b1;
        wait_ticks(2);
        keys = 16'h0;
        wait_ticks(10);
        check("t2_down_low", down, 1'b0);
        check("t2_row_idle", row, 4'h0);
        check("t2_code_kept", code, 4'h9);

        // Row 0, cols 3 and 1 together, then a bouncy release.
        align();
        keys[3] = 1'b1;
        keys[1] = 1'b1;
        q.push_back('{4'h1, edge_n + TPER * (2 + 0 + DEB)});
        wait_ticks(20);
        check("t3_down_held", down, 1'b1);
        keys = 16'h0;
        wait_ticks(2);
        keys[3] = 1'b1;
        keys[1] = 1'b1;
        wait_ticks(1);
        keys = 16'h0;
        wait_ticks(1);
        check("t3_down_through_bounce", down, 1'b1);
        check("t3_code", code, 4'h1);
        wait_ticks(10);
        check("t3_down_released", down, 1'b0);

        // Key F; reset pulsed while debouncing, then the held key is accepted once.
        align();
        keys[15] = 1'b1;
        wait_ticks(6);
        rst_n = 1'b0;
        #1;
        check("t4_rst_row", row, 4'h0);
        check("t4_rst_code", code, 4'h0);
        check("t4_rst_valid", valid, 1'b0);
        check("t4_rst_down", down, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.push_back('{4'hF, edge_n + TPER * (2 + 3 + DEB)});
        wait_ticks(40);
        check("t4_down_held", down, 1'b1);
        check("t4_code", code, 4'hF);
        keys = 16'h0;
        wait_ticks(12);
        check("t4_down_released", down, 1'b0);

        // Key 6 (row 1, col 2) held 35 ticks past acceptance.
        align();
        a_edge = edge_n + TPER * (2 + 1 + DEB);
        press(6, 1);
`ifdef KEYPAD_REPEAT_EN
        for (int k = 1; k <= 3; k++) q.push_back('{4'h6, a_edge + TPER * REP * k});
`endif
        wait_ticks(2 + 1 + DEB + 35);
        check("t5_down_held", down, 1'b1);
        check("t5_code", code, 4'h6);
        keys = 16'h0;
        wait_ticks(12);
        check("t5_down_released", down, 1'b0);

        check("pending_expected_events", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
